// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction prefetch queue.
//   fetch_state_t : prefetch FSM states (FETCH issues requests, DRAIN drops
//                   responses belonging to a squashed fetch stream).
//   fetch_entry_t : one queue entry, a PC tag plus its instruction word.
//                   The PC field is sized for the widest supported ADDR_W;
//                   narrower PCs are zero-extended on push and truncated on read.
package fetch_pkg;

   localparam int INSTR_W  = 32;
   localparam int PC_MAX_W = 32;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [PC_MAX_W-1:0] pc;
      logic [INSTR_W-1:0]  instr;
   } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry circular buffer of fetch entries.
//   clk, reset  : clock and synchronous active-low reset
//   clear       : drop all entries (takes priority over push/pop)
//   push        : write push_data at the tail
//   push_data   : entry to write
//   pop         : advance the head
//   head        : entry at the head, read straight from storage
//   count       : number of occupied entries
// The owner guarantees no push when full and no pop when empty. DEPTH is a
// power of two, so the pointers wrap by natural overflow.
module prefetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   output fetch_entry_t       head,
   output logic [CNT_W-1:0]   count
);

   fetch_entry_t       mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction prefetcher between instruction
// memory and the IF/ID register.
//   clk, reset        : clock and synchronous active-low reset
//   redirect          : branch/jump taken in ID; flush and restart fetching
//   redirect_pc       : new fetch word address
//   imem_req/addr     : read request and its word address
//   imem_gnt          : request accepted this cycle
//   imem_rvalid/rdata : read data, returned in request order
//   out_valid/instr/pc: head of the queue toward decode
//   out_ready         : decode takes the head this cycle
//   count             : occupied queue entries
//
// Handshakes: a memory request transfers on a cycle with imem_req && imem_gnt;
// a queue entry transfers to decode on a cycle with out_valid && out_ready.
// The valid side never depends combinationally on its own ready input, and a
// redirect voids any decode transfer in the same cycle.
//
// Credits: queued entries plus outstanding requests never exceed DEPTH, so a
// response always finds space. After a redirect, every request still in
// flight is counted in discard and its response dropped in DRAIN.
module instr_prefetch_queue
   import fetch_pkg::*;
#(
   parameter  int               DEPTH    = 4,
   parameter  int               ADDR_W   = 32,
   parameter  logic [ADDR_W-1:0] RESET_PC = '0,
   localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [31:0]        imem_rdata,
   output logic               out_valid,
   output logic [31:0]        out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   input  logic               out_ready,
   output logic [CNT_W-1:0]   count
);

   fetch_state_t       state, state_nxt;
   logic [ADDR_W-1:0]  fetch_pc, fetch_pc_nxt;
   logic [ADDR_W-1:0]  resp_pc, resp_pc_nxt;   // PC tag of the next kept response
   logic [CNT_W-1:0]   outstanding, outstanding_nxt;
   logic [CNT_W-1:0]   discard, discard_nxt;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W:0]     used;
   logic [CNT_W:0]     inflight_after;
   logic               fire;
   logic               resp_live;
   logic               push;
   logic               pop;
   fetch_entry_t       push_entry;
   fetch_entry_t       head;

   assign used      = {1'b0, fifo_count} + {1'b0, outstanding};
   assign imem_req  = reset && (state == FETCH) && (used < (CNT_W + 1)'(DEPTH));
   assign imem_addr = fetch_pc;
   assign fire      = imem_req && imem_gnt;

   // A response with nothing in flight and nothing to discard is stray.
   assign resp_live = imem_rvalid && ((outstanding != '0) || (discard != '0));
   assign push      = resp_live && (state == FETCH) && !redirect;

   assign out_valid = reset && (fifo_count != '0);
   assign pop       = out_valid && out_ready && !redirect;

   // Requests still unanswered after this cycle; on a redirect all of them
   // become discards, including one granted in the same cycle.
   assign inflight_after = {1'b0, discard} + {1'b0, outstanding}
                         + (CNT_W + 1)'(fire) - (CNT_W + 1)'(resp_live);

   always_comb begin
      state_nxt       = state;
      fetch_pc_nxt    = fetch_pc;
      resp_pc_nxt     = resp_pc;
      outstanding_nxt = outstanding;
      discard_nxt     = discard;
      if (fire) begin
         fetch_pc_nxt = fetch_pc + 1'b1;
      end
      if (push) begin
         resp_pc_nxt = resp_pc + 1'b1;
      end
      if (redirect) begin
         fetch_pc_nxt    = redirect_pc;
         resp_pc_nxt     = redirect_pc;
         outstanding_nxt = '0;
         discard_nxt     = inflight_after[CNT_W-1:0];
         state_nxt       = (inflight_after == '0) ? FETCH : DRAIN;
      end else if (state == FETCH) begin
         outstanding_nxt = outstanding + CNT_W'(fire) - CNT_W'(resp_live);
      end else begin
         if (resp_live) begin
            discard_nxt = discard - 1'b1;
         end
         if (discard_nxt == '0) begin
            state_nxt = FETCH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         resp_pc     <= resp_pc_nxt;
         outstanding <= outstanding_nxt;
         discard     <= discard_nxt;
      end
   end

   assign push_entry.pc    = PC_MAX_W'(resp_pc);
   assign push_entry.instr = imem_rdata;

   prefetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (redirect),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count)
   );

   assign out_instr = head.instr;
   assign out_pc    = head.pc[ADDR_W-1:0];
   assign count     = reset ? fifo_count : '0;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: scoreboard bench for instr_prefetch_queue.
// A fixed-latency memory model answers requests in order with a hash of the
// address; the scoreboard holds the PC sequence decode must see next.
module tb_instr_prefetch_queue;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic [2:0]  count;

   // narrow-PC instance for wrap-around
   logic        redirect2;
   logic [3:0]  redirect_pc2;
   logic        req2;
   logic [3:0]  addr2;
   logic        gnt2;
   logic        rvalid2;
   logic [31:0] rdata2;
   logic        ov2;
   logic [31:0] oi2;
   logic [3:0]  op2;
   logic        ready2;
   logic [2:0]  cnt2;

   instr_prefetch_queue #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_ready(out_ready), .count(count)
   );

   instr_prefetch_queue #(.DEPTH(4), .ADDR_W(4), .RESET_PC(4'hE)) dut_small (
      .clk(clk), .reset(reset), .redirect(redirect2), .redirect_pc(redirect_pc2),
      .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
      .imem_rvalid(rvalid2), .imem_rdata(rdata2),
      .out_valid(ov2), .out_instr(oi2), .out_pc(op2),
      .out_ready(ready2), .count(cnt2)
   );

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return (pc * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction

   int n_checks = 0;
   int n_fail   = 0;
   int n_pop    = 0;
   int n_grants = 0;
   int lat      = 1;
   int cyc      = 0;
   logic mon_en = 1'b0;

   logic [31:0] exp_q[$];
   logic [31:0] mf_addr[$];
   int          mf_due[$];

   // ---------------- memory models ----------------
   logic        fire_s;
   logic [31:0] addr_s;
   logic        rst_s;
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         fire_s = imem_req && imem_gnt;
         addr_s = imem_addr;
         @(posedge clk);
         rst_s = reset;
         #1;
         cyc++;
         if (!rst_s) begin
            mf_addr.delete();
            mf_due.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
         end else begin
            if (fire_s) begin
               mf_addr.push_back(addr_s);
               mf_due.push_back(cyc + lat - 1);
               n_grants++;
            end
            if (mf_addr.size() > 0 && mf_due[0] <= cyc) begin
               imem_rvalid = 1'b1;
               imem_rdata  = instr_of(mf_addr.pop_front());
               void'(mf_due.pop_front());
            end else begin
               imem_rvalid = 1'b0;
               imem_rdata  = '0;
            end
         end
      end
   end

   logic       f2;
   logic [3:0] a2;
   logic       r2;
   initial begin
      redirect2    = 1'b0;
      redirect_pc2 = '0;
      gnt2         = 1'b1;
      ready2       = 1'b1;
      rvalid2      = 1'b0;
      rdata2       = '0;
      forever begin
         @(negedge clk);
         f2 = req2 && gnt2;
         a2 = addr2;
         @(posedge clk);
         r2 = reset;
         #1;
         rvalid2 = f2 && r2;
         rdata2  = instr_of({28'b0, a2});
      end
   end

   // ---------------- scoreboard ----------------
   logic [31:0] sb_e;
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && reset && out_valid && out_ready && !redirect) begin
            n_checks++;
            n_pop++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_empty: got pc=%h, required no output", out_pc);
            end else begin
               sb_e = exp_q.pop_front();
               if (out_pc !== sb_e || out_instr !== instr_of(sb_e)) begin
                  n_fail++;
                  $display("FAIL sb_order: got pc=%h instr=%h, required pc=%h instr=%h",
                           out_pc, out_instr, sb_e, instr_of(sb_e));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required test completion");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_exp(input logic [31:0] start);
      exp_q.delete();
      for (int i = 0; i < 256; i++) exp_q.push_back(start + i);
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      redirect = 1'b0;
      repeat (2) tick();
      fill_exp(32'h0);
      reset = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
      out_ready = 1'b1; imem_gnt = 1'b1; lat = 1;
      repeat (3) tick();
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b, required 0", imem_req); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
      n_checks++;
      if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", count); end
      tick();
      fill_exp(32'h0);
      mon_en = 1'b1;
      reset  = 1'b1;
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++; $display("FAIL first_req: got req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
      end
   endtask

   task automatic test_stream();
      int p0;
      tick(); tick();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid: cycle %0d got %b, required 1", i, out_valid); end
         tick();
      end
      for (int i = 0; i < 40; i++) begin
         imem_gnt  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      imem_gnt = 1'b1; out_ready = 1'b1;
      p0 = n_pop;
      repeat (30) tick();
      @(negedge clk);
      n_checks++;
      if (n_pop - p0 < 25) begin n_fail++; $display("FAIL stream_resume: got %0d pops, required >= 25", n_pop - p0); end
   endtask

   task automatic test_backpressure();
      int g0, p0;
      out_ready = 1'b0; imem_gnt = 1'b1; lat = 1;
      tick();
      do_reset();
      g0 = n_grants;
      repeat (12) tick();
      @(negedge clk);
      n_checks++;
      if (n_grants - g0 != 4) begin n_fail++; $display("FAIL bp_grants: got %0d, required 4", n_grants - g0); end
      n_checks++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %b, required 0", imem_req); end
      n_checks++;
      if (count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d, required 4", count); end
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
         n_fail++; $display("FAIL bp_head: got valid=%b pc=%h, required valid=1 pc=0", out_valid, out_pc);
      end
      tick();
      out_ready = 1'b1;
      p0 = n_pop;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_no_gap: cycle %0d got %b, required 1", i, out_valid); end
         tick();
      end
      n_checks++;
      if (n_pop - p0 != 20) begin n_fail++; $display("FAIL bp_pops: got %0d, required 20", n_pop - p0); end
   endtask

   task automatic test_redirect_drain();
      int p0;
      out_ready = 1'b1; imem_gnt = 1'b1; lat = 3;
      do_reset();
      tick();
      redirect = 1'b1; redirect_pc = 32'h40;
      fill_exp(32'h40);
      tick();
      redirect = 1'b0;
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b0 || count !== 3'd0) begin
         n_fail++; $display("FAIL drain_flush: got req=%b count=%0d, required req=0 count=0", imem_req, count);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         @(negedge clk);
         n_checks++;
         if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drain_req0: step %0d got %b, required 0", i, imem_req); end
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         n_fail++; $display("FAIL drain_restart: got req=%b addr=%h, required req=1 addr=40", imem_req, imem_addr);
      end
      p0 = n_pop;
      repeat (12) tick();
      n_checks++;
      if (n_pop - p0 < 5) begin n_fail++; $display("FAIL drain_outputs: got %0d pops, required >= 5", n_pop - p0); end
   endtask

   task automatic test_redirect_same_cycle();
      int p0;
      out_ready = 1'b1; imem_gnt = 1'b1; lat = 2;
      do_reset();
      tick(); tick();
      redirect = 1'b1; redirect_pc = 32'h80;
      fill_exp(32'h80);
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1) begin n_fail++; $display("FAIL same_pre: got req=%b, required 1", imem_req); end
      tick();
      redirect = 1'b0;
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b0 || count !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL same_flush: got req=%b count=%0d valid=%b, required 0/0/0", imem_req, count, out_valid);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL same_drop: got req=%b valid=%b, required 0/0", imem_req, out_valid);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h80 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL same_restart: got req=%b addr=%h valid=%b, required 1/80/0", imem_req, imem_addr, out_valid);
      end
      p0 = n_pop;
      repeat (12) tick();
      n_checks++;
      if (n_pop - p0 < 5) begin n_fail++; $display("FAIL same_outputs: got %0d pops, required >= 5", n_pop - p0); end
   endtask

   task automatic test_reset_mid();
      int p0;
      out_ready = 1'b0; imem_gnt = 1'b1; lat = 1;
      do_reset();
      repeat (4) tick();
      @(negedge clk);
      n_checks++;
      if (count !== 3'd3 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL mid_pre: got count=%0d req=%b, required 3/0", count, imem_req);
      end
      #1;
      reset = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || count !== 3'd0 || imem_addr !== 32'h0 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: got valid=%b count=%0d addr=%h req=%b, required 0/0/0/0",
                            out_valid, count, imem_addr, imem_req);
      end
      tick();
      fill_exp(32'h0);
      out_ready = 1'b1;
      reset     = 1'b1;
      p0 = n_pop;
      repeat (12) tick();
      n_checks++;
      if (n_pop - p0 < 5) begin n_fail++; $display("FAIL mid_recover: got %0d pops, required >= 5", n_pop - p0); end
   endtask

   task automatic test_addr_wrap();
      int         got;
      logic [3:0] pcs [4];
      logic [31:0] ins [4];
      logic [3:0] wrap_exp [4];
      wrap_exp[0] = 4'hE; wrap_exp[1] = 4'hF; wrap_exp[2] = 4'h0; wrap_exp[3] = 4'h1;
      got = 0;
      do_reset();
      for (int c = 0; c < 20 && got < 4; c++) begin
         @(negedge clk);
         if (ov2) begin
            pcs[got] = op2;
            ins[got] = oi2;
            got++;
         end
      end
      n_checks++;
      if (got != 4) begin n_fail++; $display("FAIL wrap_count: got %0d outputs, required 4", got); end
      for (int i = 0; i < got; i++) begin
         n_checks++;
         if (pcs[i] !== wrap_exp[i] || ins[i] !== instr_of({28'b0, wrap_exp[i]})) begin
            n_fail++; $display("FAIL wrap_pc: idx %0d got pc=%h instr=%h, required pc=%h instr=%h",
                               i, pcs[i], ins[i], wrap_exp[i], instr_of({28'b0, wrap_exp[i]}));
         end
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drain();
      test_redirect_same_cycle();
      test_reset_mid();
      test_addr_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch queue sitting between instruction memory and the IF/ID pipeline register of the five-stage MIPS pipeline. It generates sequential word addresses, issues read requests to instruction memory under a credit limit, and buffers returned instructions with their PCs in an in-order queue. The decode stage consumes them through a valid/ready handshake. A redirect from branch/jump resolution in ID flushes the queue and discards in-flight responses.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2; also the cap on outstanding memory requests
- ADDR_W, 32: word-address width of the PC
- RESET_PC, 0: first fetch address after reset
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- redirect  in  1  branch/jump taken in ID; flush and restart at redirect_pc
- redirect_pc  in  ADDR_W  new fetch word address
- imem_req  out  1  read request valid
- imem_addr  out  ADDR_W  request word address (= fetch_pc)
- imem_gnt  in  1  request accepted this cycle (meaningful only with imem_req)
- imem_rvalid  in  1  read data returned, in request order
- imem_rdata  in  32  instruction word
- out_valid  out  1  head entry valid
- out_instr  out  32  head instruction
- out_pc  out  ADDR_W  head PC
- out_ready  in  1  decode accepts head this cycle
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Registers: fetch_pc, queue (entries {pc, instr}), count, outstanding, discard, state.
- FSM states FETCH, DRAIN.
  - FETCH: imem_req = (count + outstanding < DEPTH). On imem_req && imem_gnt: fetch_pc += 1 (modulo 2^ADDR_W), outstanding += 1. Each accepted response pushes {pc tag, imem_rdata}; pc tag held in a parallel in-flight PC queue, or the push PC counter. outstanding -= 1 per rvalid.
  - DRAIN: imem_req = 0. Each rvalid decrements discard and is dropped. When discard reaches 0 (including the cycle rvalid takes it 1→0) → FETCH.
- Redirect (any state, highest priority after reset): queue cleared (count=0), fetch_pc ← redirect_pc, discard ← outstanding + (imem_req&&imem_gnt) − imem_rvalid, outstanding ← 0. Any pop that cycle is void. If computed discard = 0 → FETCH, else → DRAIN. A redirect in DRAIN accumulates the same way.
- Pop: out_valid && out_ready && !redirect → head advances, count −1. Push and pop in the same cycle leave count unchanged.
- Credit rule guarantees a push never finds the queue full; rvalid with outstanding=0 and discard=0 is ignored.
- out_valid = (count != 0); out_instr/out_pc driven from storage (first-word fall-through, no extra register).

## Timing
- Reset (reset=0 at edge): fetch_pc=RESET_PC, count=0, outstanding=0, discard=0, state=FETCH, queue pointers 0. During reset imem_req=0, out_valid=0, count=0; out_instr/out_pc are don't-care (0 in simulation).
- First imem_req in the first cycle with reset=1.
- Response-to-output latency: rvalid at edge t → out_valid visible after edge t (cycle t+1).
- Redirect at edge t → imem_req with imem_addr=redirect_pc in cycle t+1 if discard=0, else the cycle after the last discarded rvalid.
- Sustained throughput one instruction/cycle with single-cycle memory and out_ready=1.
- Reset mid-operation clears all state; instruction memory shares the same reset, so no stale responses arrive.

## Structure
- Package fetch_pkg: state enum {FETCH, DRAIN}; typedef fetch_entry_t {logic [ADDR_W-1:0] pc; logic [31:0] instr}.
- Sub-module prefetch_fifo: DEPTH-entry circular buffer (push/pop/clear, wrap-around pointers, count). Top holds FSM, credit and discard counters, PC generation.

## Test plan
- Reset, RESET_PC=0, memory latency 1, gnt=1, out_ready=1 → out_pc 0,1,2,3… each cycle from cycle 2, out_instr = mem[pc].
- out_ready=0 → exactly 4 grants then imem_req=0, count=4; raise out_ready → pcs continue with no gap, loss or duplicate.
- Latency 3, redirect to 0x40 with 2 in flight → DRAIN, 2 responses dropped, next out_pc=0x40.
- Redirect in the same cycle as gnt and rvalid with outstanding=2 → discard=2, both later responses dropped, no queue entry survives.
- ADDR_W=4, RESET_PC=0xE → out_pc 0xE,0xF,0x0,0x1.
- Assert reset with count=3, outstanding=1 → next cycle out_valid=0, count=0, imem_addr=RESET_PC.
